// File: rtl/frame_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_loader_pkg
// Summary  : Shared class codes, FSM encodings and defaults for frame_loader.
// Revision : 1.0
// ============================================================================
package frame_loader_pkg;

  localparam int DEF_WIDTH = 25;

  typedef enum logic [1:0] {
    CLS_NONE    = 2'b00,
    CLS_CIRCLE  = 2'b01,
    CLS_CROSS   = 2'b10,
    CLS_TIMEOUT = 2'b11
  } cls_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EVAL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Longest evaluation allowed: a stale pass, a full pass and margin.
  function automatic int timeout_cycles(input int width);
    return 3 * width + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_loader_pixel_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : frame_loader_pixel_deserializer
// Summary  : Collects a row-major pixel stream into a shadow frame buffer.
// Revision : 1.0
// ============================================================================
module frame_loader_pixel_deserializer
  import frame_loader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_pixel,
  input  logic             s_sof,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             take,
  output logic [WIDTH-1:0] shadow,
  output logic             full,
  output logic             err_sof
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);
  localparam logic [CW-1:0] c_one  = CW'(1);

  logic [WIDTH-1:0] r_shadow;
  logic [CW-1:0]    r_cnt;
  logic             r_full;
  logic             r_err_sof;
  logic             w_accept;

  assign w_accept = s_valid & ~r_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow  <= '0;
      r_cnt     <= '0;
      r_full    <= 1'b0;
      r_err_sof <= 1'b0;
    end else begin
      r_err_sof <= 1'b0;
      if (take) r_full <= 1'b0;
      if (w_accept) begin
        if (s_sof) begin
          r_shadow[0] <= s_pixel;
          r_cnt       <= c_one;
          r_err_sof   <= (r_cnt != '0);
        end else if (r_cnt != '0) begin
          // Beats without sof at count 0 fall through here and are dropped.
          r_shadow[r_cnt] <= s_pixel;
          if (r_cnt == c_last) begin
            r_full <= 1'b1;
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign s_ready = ~r_full;
  assign shadow  = r_shadow;
  assign full    = r_full;
  assign err_sof = r_err_sof;

endmodule
`default_nettype wire

// File: rtl/frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : frame_loader
// Summary  : Double-buffered frame feeder and result collector for the perceptron.
// Revision : 1.0
// ============================================================================
module frame_loader
  import frame_loader_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = timeout_cycles(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_pixel,
  input  logic             s_sof,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] p_in,
  output logic             p_en,
  input  logic [1:0]       p_out,
  input  logic             p_ready,
  output logic [1:0]       res_class,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             err_sof,
  output logic             err_timeout
);

  localparam int EW = $clog2(TIMEOUT + 1);
  localparam logic [EW-1:0] c_ecnt_min = EW'(WIDTH);
  localparam logic [EW-1:0] c_ecnt_max = EW'(TIMEOUT);

  logic [1:0]       r_state;
  logic [EW-1:0]    r_ecnt;
  logic [WIDTH-1:0] r_p_in;
  logic             r_p_en;
  logic [1:0]       r_res_class;
  logic             r_res_valid;
  logic             r_err_timeout;

  logic [WIDTH-1:0] w_shadow;
  logic             w_full;
  logic             w_take;

  // Loading clears full on the same edge, so a fill write can never collide.
  assign w_take = w_full & ((r_state == ST_IDLE) | ((r_state == ST_DONE) & res_ready));

  frame_loader_pixel_deserializer #(
    .WIDTH (WIDTH)
  ) u_deser (
    .clk     (clk),
    .rst     (rst),
    .s_pixel (s_pixel),
    .s_sof   (s_sof),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .take    (w_take),
    .shadow  (w_shadow),
    .full    (w_full),
    .err_sof (err_sof)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_ecnt        <= '0;
      r_p_in        <= '0;
      r_p_en        <= 1'b0;
      r_res_class   <= CLS_NONE;
      r_res_valid   <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_p_in  <= w_shadow;
            r_ecnt  <= '0;
            r_p_en  <= 1'b1;
            r_state <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          r_ecnt <= r_ecnt + 1'b1;
          // Early strobes come from a perceptron left mid-count; let it wrap.
          if (p_ready && (r_ecnt >= c_ecnt_min)) begin
            r_res_class <= p_out;
            r_res_valid <= 1'b1;
            r_p_en      <= 1'b0;
            r_state     <= ST_DONE;
          end else if (r_ecnt == c_ecnt_max) begin
            r_res_class   <= CLS_TIMEOUT;
            r_res_valid   <= 1'b1;
            r_err_timeout <= 1'b1;
            r_p_en        <= 1'b0;
            r_state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            if (w_take) begin
              r_p_in  <= w_shadow;
              r_ecnt  <= '0;
              r_p_en  <= 1'b1;
              r_state <= ST_EVAL;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign p_in        = r_p_in;
  assign p_en        = r_p_en;
  assign res_class   = r_res_class;
  assign res_valid   = r_res_valid;
  assign busy        = (r_state == ST_EVAL) | (r_state == ST_DONE);
  assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_loader
// Summary  : Scoreboard bench for frame_loader driving a behavioural perceptron.
// Revision : 1.0
// ============================================================================
module tb_frame_loader;

  localparam int W  = 25;
  localparam int TO = 3 * W + 2;

  localparam logic [W-1:0] FRM_CROSS  = 25'h1101011;  // bits 0,4,12,20,24
  localparam logic [W-1:0] FRM_CIRCLE = 25'hE8C62E;   // outer ring minus corners
  localparam logic [W-1:0] FRM_ZERO   = 25'h0;

  logic         clk;
  logic         rst;
  logic         s_pixel, s_sof, s_valid, s_ready;
  logic [W-1:0] p_in;
  logic         p_en;
  logic [1:0]   p_out;
  logic         p_ready;
  logic [1:0]   res_class;
  logic         res_valid, res_ready, busy, err_sof, err_timeout;
  logic         stub;

  int checks   = 0;
  int failures = 0;
  int n_sof    = 0;
  int n_to     = 0;
  logic [1:0] exp_q[$];

  frame_loader #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_pixel     (s_pixel),
    .s_sof       (s_sof),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .p_in        (p_in),
    .p_en        (p_en),
    .p_out       (p_out),
    .p_ready     (p_ready),
    .res_class   (res_class),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .busy        (busy),
    .err_sof     (err_sof),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial perceptron: one pixel per enabled cycle, strobe after the last, never reset.
  logic [5:0]   pc       = 6'd0;
  int           acc_x    = 0;
  int           acc_o    = 0;
  logic         perc_rdy = 1'b0;
  logic [1:0]   perc_out = 2'b00;
  logic [W-1:0] cross_m  = 25'h1151151;
  logic [W-1:0] circle_m = 25'hE8C62E;

  always @(posedge clk) begin
    if (perc_rdy) begin
      perc_rdy <= 1'b0;
      pc       <= 6'd0;
      acc_x    <= 0;
      acc_o    <= 0;
    end else if (p_en === 1'b1) begin
      if (pc == 6'd25) begin
        perc_rdy <= 1'b1;
        perc_out <= (acc_x >= 5) ? 2'b10 : ((acc_o >= 8) ? 2'b01 : 2'b00);
      end else begin
        acc_x <= acc_x + int'(p_in[pc[4:0]] & cross_m[pc[4:0]]);
        acc_o <= acc_o + int'(p_in[pc[4:0]] & circle_m[pc[4:0]]);
        pc    <= pc + 6'd1;
      end
    end
  end

  assign p_out   = perc_out;
  assign p_ready = stub ? 1'b0 : perc_rdy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Monitor: scoreboard pops, error pulse counting, p_in stability while enabled.
  initial begin
    logic [1:0]   e;
    logic         prev_en  = 1'b0;
    logic [W-1:0] prev_pin = '0;
    forever begin
      @(negedge clk);
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got %0h expected none", res_class);
        end else begin
          e = exp_q.pop_front();
          check("res_class", {30'd0, res_class}, {30'd0, e});
        end
      end
      if (err_sof === 1'b1) n_sof++;
      if (err_timeout === 1'b1) n_to++;
      if (p_en === 1'b1 && prev_en) check("p_in_stable", p_in, prev_pin);
      prev_en  = (p_en === 1'b1);
      prev_pin = p_in;
    end
  end

  task automatic send_frame(input logic [W-1:0] f, input int nb, input bit push, input logic [1:0] e);
    int n;
    if (push) exp_q.push_back(e);
    for (int i = 0; i < nb; i++) begin
      s_valid = 1'b1;
      s_pixel = f[i];
      s_sof   = (i == 0);
      n = 0;
      while (s_ready !== 1'b1 && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (n >= 400) bound_fail("s_ready_wait");
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic wait_pen();
    int n = 0;
    while (p_en !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) bound_fail("p_en_wait");
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) bound_fail("drain");
    repeat (2) @(negedge clk);
  endtask

  task automatic set_rr(input logic v);
    @(posedge clk);
    #1 res_ready = v;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int base_sof, base_to;
    rst = 1'b1; s_valid = 1'b0; s_pixel = 1'b0; s_sof = 1'b0;
    res_ready = 1'b1; stub = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_p_en", p_en, 0);
    check("rst_p_in", p_in, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_class", res_class, 0);
    check("rst_busy", busy, 0);
    check("rst_err", {err_sof, err_timeout}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Stray beats without sof are dropped silently.
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_pixel = 1'b1; s_sof = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("stray_busy", busy, 0);
    check("stray_s_ready", s_ready, 1);
    check("stray_err_sof", n_sof, 0);

    // Cross frame and clean-start latency.
    send_frame(FRM_CROSS, W, 1'b1, 2'b10);
    wait_pen();
    check("load_p_in", p_in, FRM_CROSS);
    n = 0;
    while (res_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("result_latency", n, W + 2);
    drain();

    // Back-to-back frames with a stalled result port.
    set_rr(1'b0);
    fork
      begin
        send_frame(FRM_CROSS, W, 1'b1, 2'b10);
        send_frame(FRM_CIRCLE, W, 1'b1, 2'b01);
        send_frame(FRM_ZERO, W, 1'b1, 2'b00);
      end
      begin
        n = 0;
        while (res_valid !== 1'b1 && n < 200) begin
          @(negedge clk);
          n++;
        end
        if (n >= 200) bound_fail("bp_res_valid");
        repeat (40) @(negedge clk);
        check("bp_s_ready", s_ready, 0);
        check("bp_held_valid", res_valid, 1);
        check("bp_held_class", res_class, 2'b10);
        check("bp_busy", busy, 1);
        set_rr(1'b1);
      end
    join
    drain();

    // Early sof drops a partial frame.
    base_sof = n_sof;
    send_frame(FRM_CROSS, 10, 1'b0, 2'b00);
    send_frame(FRM_CIRCLE, W, 1'b1, 2'b01);
    drain();
    check("err_sof_count", n_sof - base_sof, 1);

    // Perceptron silenced: timeout path.
    stub = 1'b1;
    base_to = n_to;
    send_frame(FRM_CROSS, W, 1'b1, 2'b11);
    wait_pen();
    n = 0;
    while (err_timeout !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", n, TO + 1);
    drain();
    check("err_timeout_count", n_to - base_to, 1);
    stub = 1'b0;

    // Reset in the middle of an evaluation.
    base_sof = n_sof;
    base_to  = n_to;
    send_frame(FRM_CIRCLE, W, 1'b0, 2'b00);
    wait_pen();
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_p_en", p_en, 0);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    send_frame(FRM_CROSS, W, 1'b1, 2'b10);
    drain();
    check("midrst_pulses", (n_sof - base_sof) + (n_to - base_to), 0);

    // All-zero frame.
    send_frame(FRM_ZERO, W, 1'b1, 2'b00);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
